// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state type
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 16;
    localparam int UART_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser for an asynchronous single-bit input
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops; reset to the line's idle level so no false edge appears
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: start validation, mid-bit sampling, stop check, holding register
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    rx_state_t              r_state;
    rx_state_t              w_state_next;
    logic [CW-1:0]          r_cnt;
    logic [BW-1:0]          r_bit;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid;
    logic                   r_frame_err;
    logic                   r_overrun;
    logic                   w_rx_s;
    logic                   w_cnt_run;
    logic                   w_sample;
    logic                   w_good_stop;
    logic                   w_bad_stop;
    logic                   w_load;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (rx),
        .o_sync  (w_rx_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus decode of the mid-bit sample points (half period for start, full period after)
    always_comb begin
        w_state_next = r_state;
        w_cnt_run    = 1'b0;
        w_sample     = 1'b0;
        w_good_stop  = 1'b0;
        w_bad_stop   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rx_s) w_state_next = START;
            end
            START: begin
                w_cnt_run = 1'b1;
                if (r_cnt == HALF_LAST) begin
                    w_sample     = 1'b1;
                    w_state_next = w_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                w_cnt_run = 1'b1;
                if (r_cnt == FULL_LAST) begin
                    w_sample = 1'b1;
                    if (r_bit == LAST_BIT) w_state_next = STOP;
                end
            end
            STOP: begin
                w_cnt_run = 1'b1;
                if (r_cnt == FULL_LAST) begin
                    w_sample = 1'b1;
                    if (w_rx_s) begin
                        w_good_stop  = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_bad_stop   = 1'b1;
                        w_state_next = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (w_rx_s) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // A good stop loads the holding register if it is empty or being emptied this very cycle
    assign w_load = w_good_stop && (!r_valid || rx_ready);

    // Frame-relative bit timer, bit index and LSB-first shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            if (!w_cnt_run || w_sample) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (r_state == START) begin
                r_bit <= '0;
            end else if (r_state == DATA && w_sample) begin
                r_bit <= r_bit + BW'(1);
            end
            if (r_state == DATA && w_sample) begin
                r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            end
        end
    end

    // Holding register handshake and one-cycle error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_bad_stop;
            r_overrun   <= w_good_stop && r_valid && !rx_ready;
            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int DB  = 8;
    localparam int TS_OFS = CPB / 2 + (DB + 1) * CPB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx = 1'b1;
    logic          rx_ready = 1'b1;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          overrun;
    logic          busy;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit run = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Timestamp model: line value seen by the decoder lags the pin by two edges; a frame
    // is anchored at the edge that first sees 0 while idle and sampled at fixed offsets.
    logic [1:0]    m_dly = 2'b11;
    int            m_mode = 0;
    int            m_e0 = 0;
    int            m_n = 0;
    logic [DB-1:0] m_bits = '0;
    logic [DB-1:0] m_data = '0;
    logic          m_valid = 1'b0;
    logic          m_ferr = 1'b0;
    logic          m_ovr = 1'b0;
    logic          m_busy = 1'b0;

    always @(posedge clk) begin
        logic s;
        int   k;
        logic deliver;
        m_n++;
        s = m_dly[1];
        if (rst) begin
            m_dly   = 2'b11;
            m_mode  = 0;
            m_bits  = '0;
            m_data  = '0;
            m_valid = 1'b0;
            m_ferr  = 1'b0;
            m_ovr   = 1'b0;
            m_busy  = 1'b0;
        end else begin
            deliver = 1'b0;
            m_ferr  = 1'b0;
            m_ovr   = 1'b0;
            if (m_mode == 0) begin
                if (!s) begin
                    m_mode = 1;
                    m_e0   = m_n;
                end
            end else if (m_mode == 1) begin
                k = m_n - m_e0;
                if (k == CPB / 2) begin
                    if (s) m_mode = 0;
                end else if (k > CPB / 2 && k < TS_OFS && ((k - CPB / 2) % CPB) == 0) begin
                    m_bits[(k - CPB / 2) / CPB - 1] = s;
                end else if (k == TS_OFS) begin
                    if (s) begin
                        deliver = 1'b1;
                        m_mode  = 0;
                    end else begin
                        m_ferr = 1'b1;
                        m_mode = 2;
                    end
                end
            end else begin
                if (s) m_mode = 0;
            end
            if (deliver && (!m_valid || rx_ready)) begin
                m_valid = 1'b1;
                m_data  = m_bits;
            end else begin
                if (deliver) m_ovr = 1'b1;
                if (m_valid && rx_ready) m_valid = 1'b0;
            end
            m_busy = (m_mode != 0);
            m_dly  = {m_dly[0], rx};
        end
    end

    int n_ferr = 0;
    int n_ovr  = 0;
    int n_acc  = 0;

    // Per-cycle comparison against the model, plus event counters for the directed checks
    always @(negedge clk) begin
        if (run) begin
            chk("valid", rx_valid, m_valid);
            if (m_valid) chk("data", rx_data, m_data);
            chk("frame_err", frame_err, m_ferr);
            chk("overrun", overrun, m_ovr);
            chk("busy", busy, m_busy);
            if (frame_err) n_ferr++;
            if (overrun) n_ovr++;
            if (rx_valid && rx_ready) n_acc++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int extra_low);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
        drive_bit(stop_v);
        if (extra_low > 0) begin
            rx = 1'b0;
            tick(extra_low);
        end
        rx = 1'b1;
    endtask

    task automatic wait_valid(input int maxc, output logic [7:0] d, output logic b, output int c);
        bit ok;
        ok = 1'b0;
        d  = '0;
        b  = 1'b0;
        c  = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (rx_valid) begin
                ok = 1'b1;
                d  = rx_data;
                b  = busy;
                c  = cyc;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_valid actual=timeout expected=rx_valid within %0d cycles", maxc);
        end
    endtask

    int         t_edge;
    int         t_c;
    int         base;
    logic [7:0] t_d;
    logic       t_b;

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        rx_ready = 1'b1;
        tick(3);
        rst = 1'b0;
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_busy", busy, 0);
        run = 1'b1;
        tick(5);

        // Good frame: latency from pin edge and busy low right after the stop sample
        t_edge = cyc;
        base = n_ferr + n_ovr;
        fork
            send_frame(8'hA5, 1'b1, 0);
            wait_valid(400, t_d, t_b, t_c);
        join
        chk("a5_latency", t_c - t_edge, 155);
        chk("a5_data", t_d, 8'hA5);
        chk("a5_busy", t_b, 0);
        chk("a5_no_err", n_ferr + n_ovr - base, 0);
        tick(10);

        // Glitch shorter than half a bit
        t_edge = cyc;
        base = n_acc + n_ferr;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        while (cyc < t_edge + 10) @(negedge clk);
        chk("glitch_busy_t0p8", busy, 1);
        @(negedge clk);
        chk("glitch_idle_t0p9", busy, 0);
        tick(200);
        chk("glitch_valid", rx_valid, 0);
        chk("glitch_events", n_acc + n_ferr - base, 0);

        // Framing error with extended line-low, then recovery
        base = n_ferr;
        send_frame(8'h3C, 1'b0, 40);
        chk("ferr_busy_held", busy, 1);
        tick(5);
        chk("ferr_busy_drop", busy, 0);
        chk("ferr_pulses", n_ferr - base, 1);
        chk("ferr_valid", rx_valid, 0);
        tick(10);
        fork
            send_frame(8'h5A, 1'b1, 0);
            wait_valid(400, t_d, t_b, t_c);
        join
        chk("after_ferr_data", t_d, 8'h5A);
        tick(10);

        // Overrun: second byte dropped, first held until accepted
        rx_ready = 1'b0;
        base = n_ovr;
        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h22, 1'b1, 0);
        tick(5);
        chk("ovr_valid", rx_valid, 1);
        chk("ovr_data", rx_data, 8'h11);
        chk("ovr_pulses", n_ovr - base, 1);
        base = n_acc;
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        @(negedge clk);
        chk("ovr_drain_valid", rx_valid, 0);
        chk("ovr_drain_count", n_acc - base, 1);
        tick(5);

        // Accept and reload in the same cycle
        send_frame(8'h11, 1'b1, 0);
        base = n_ovr;
        fork
            send_frame(8'h22, 1'b1, 0);
            begin
                tick(TS_OFS + 2);
                rx_ready = 1'b1;
                @(negedge clk);
                chk("reload_pre_data", rx_data, 8'h11);
                tick(1);
                rx_ready = 1'b0;
                chk("reload_valid", rx_valid, 1);
                chk("reload_data", rx_data, 8'h22);
            end
        join
        chk("reload_no_ovr", n_ovr - base, 0);
        tick(5);

        // Reset during data bit 4 with a byte still pending
        fork
            send_frame(8'hFF, 1'b1, 0);
            begin
                tick(5 * CPB + CPB / 2);
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
                chk("midrst_valid", rx_valid, 0);
                chk("midrst_data", rx_data, 0);
                chk("midrst_busy", busy, 0);
                chk("midrst_ferr", frame_err, 0);
                chk("midrst_ovr", overrun, 0);
            end
        join
        tick(20);
        chk("midrst_no_byte", rx_valid, 0);
        rx_ready = 1'b1;
        fork
            send_frame(8'h81, 1'b1, 0);
            wait_valid(400, t_d, t_b, t_c);
        join
        chk("after_rst_data", t_d, 8'h81);
        tick(10);

        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
